// File: rtl/counter_sequencer.sv
// counter_sequencer: drives the load/enable/clear inputs of a binary counter
// so that each pass loads a start value and counts up to a target, repeating
// for a programmed number of passes. Supports hold, abort and a stall watchdog.
module counter_sequencer #(
  parameter int CW   = 6,
  parameter int LW   = 8,
  parameter int WDOG = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          hold,
  input  logic [CW-1:0] cfg_load_val,
  input  logic [CW-1:0] cfg_target,
  input  logic [LW-1:0] cfg_loops,
  input  logic [CW-1:0] count,
  output logic          cnt_clr,
  output logic          cnt_load,
  output logic [CW-1:0] cnt_load_val,
  output logic          cnt_en,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [LW-1:0] loops_done
);

  localparam int WW = $clog2(WDOG + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_CLEAR,
    S_ERROR
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] load_reg, target_reg, count_prev_reg;
  logic [LW-1:0] loops_reg, loops_done_reg, loops_done_next, loops_inc;
  logic [WW-1:0] wdog_reg, wdog_next, wdog_inc;
  logic          error_reg, error_next;
  logic          capture, at_target, run_en, stalled;

  // Pass-progress and stall detection feeding both the FSM and the counter
  assign at_target = (count == target_reg);
  assign run_en    = (state_reg == S_RUN) && !hold && !at_target;
  assign stalled   = run_en && (count == count_prev_reg);
  assign loops_inc = loops_done_reg + 1'b1;
  assign wdog_inc  = wdog_reg + 1'b1;

  // Counter-facing strobes are pure state decodes, so an async reset drops them at once
  assign cnt_en       = run_en;
  assign cnt_load     = (state_reg == S_LOAD);
  assign cnt_load_val = (state_reg == S_LOAD) ? load_reg : '0;
  assign cnt_clr      = (state_reg == S_CLEAR);
  assign busy         = (state_reg == S_LOAD) || (state_reg == S_RUN) || (state_reg == S_CLEAR);
  assign done         = (state_reg == S_DONE);
  assign error        = error_reg;
  assign loops_done   = loops_done_reg;

  // Next-state, loop bookkeeping and watchdog; abort overrides any transition
  always_comb begin
    state_next      = state_reg;
    loops_done_next = loops_done_reg;
    wdog_next       = wdog_reg;
    error_next      = error_reg;
    capture         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          capture         = 1'b1;
          loops_done_next = '0;
          state_next      = S_LOAD;
        end
      end
      S_LOAD: begin
        wdog_next  = '0;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (at_target) begin
          loops_done_next = loops_inc;
          state_next      = (loops_inc == loops_reg) ? S_DONE : S_LOAD;
        end else if (!hold) begin
          if (stalled) begin
            wdog_next = wdog_inc;
            if (wdog_inc >= WW'(WDOG)) state_next = S_ERROR;
          end else begin
            wdog_next = '0;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_CLEAR: begin
        error_next      = 1'b0;
        loops_done_next = '0;
        state_next      = S_IDLE;
      end
      S_ERROR: state_next = S_ERROR;
      default: state_next = S_IDLE;
    endcase
    if (abort && (state_reg != S_IDLE)) state_next = S_CLEAR;
    if (state_next == S_ERROR) error_next = 1'b1;
  end

  // State, shadow configuration and history registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      load_reg       <= '0;
      target_reg     <= '0;
      loops_reg      <= '0;
      loops_done_reg <= '0;
      wdog_reg       <= '0;
      error_reg      <= 1'b0;
      count_prev_reg <= '0;
    end else begin
      state_reg      <= state_next;
      loops_done_reg <= loops_done_next;
      wdog_reg       <= wdog_next;
      error_reg      <= error_next;
      count_prev_reg <= count;
      if (capture) begin
        load_reg   <= cfg_load_val;
        target_reg <= cfg_target;
        // a loop count of zero still runs one pass
        loops_reg  <= (cfg_loops == '0) ? LW'(1) : cfg_loops;
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: drives two sequencers (watchdog 15 and 2) with shared
// stimulus, each against its own counter model, and scores done pulses.
module tb_counter_sequencer;

  localparam int CW = 6;
  localparam int LW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          hold  = 1'b0;
  logic          stuck = 1'b0;
  logic [CW-1:0] cfg_load_val = '0;
  logic [CW-1:0] cfg_target   = '0;
  logic [LW-1:0] cfg_loops    = '0;

  logic [CW-1:0] count_a, count_b, load_val_a, load_val_b;
  logic          clr_a, clr_b, load_a, load_b, en_a, en_b;
  logic          busy_a, busy_b, done_a, done_b, error_a, error_b;
  logic [LW-1:0] loops_done_a, loops_done_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int loops;
  } exp_t;
  exp_t sb[$];

  counter_sequencer #(.CW(CW), .LW(LW), .WDOG(15)) u_dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .hold(hold),
    .cfg_load_val(cfg_load_val), .cfg_target(cfg_target), .cfg_loops(cfg_loops),
    .count(count_a), .cnt_clr(clr_a), .cnt_load(load_a), .cnt_load_val(load_val_a),
    .cnt_en(en_a), .busy(busy_a), .done(done_a), .error(error_a), .loops_done(loops_done_a)
  );

  counter_sequencer #(.CW(CW), .LW(LW), .WDOG(2)) u_dut_wd2 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .hold(hold),
    .cfg_load_val(cfg_load_val), .cfg_target(cfg_target), .cfg_loops(cfg_loops),
    .count(count_b), .cnt_clr(clr_b), .cnt_load(load_b), .cnt_load_val(load_val_b),
    .cnt_en(en_b), .busy(busy_b), .done(done_b), .error(error_b), .loops_done(loops_done_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // counter datapath models; stuck freezes the count entirely
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_a <= '0;
    else if (!stuck) begin
      if (clr_a) count_a <= '0;
      else if (load_a) count_a <= load_val_a;
      else if (en_a) count_a <= count_a + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_b <= '0;
    else if (!stuck) begin
      if (clr_b) count_b <= '0;
      else if (load_b) count_b <= load_val_b;
      else if (en_b) count_b <= count_b + 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // cycles per pass: one LOAD, one RUN cycle per count, one RUN cycle at target
  function automatic int pass_len(input int lv, input int tg);
    return (((tg - lv) % 64 + 64) % 64) + 2;
  endfunction

  // issue start from a negedge; optionally enqueue the expected done pulse
  task automatic start_seq(input int lv, input int tg, input int lp, input bit expect_done,
                           input int extra);
    int   eff;
    exp_t e;
    cfg_load_val = CW'(lv);
    cfg_target   = CW'(tg);
    cfg_loops    = LW'(lp);
    start        = 1'b1;
    if (expect_done) begin
      eff     = (lp == 0) ? 1 : lp;
      e.cyc   = cyc + eff * pass_len(lv, tg) + 1 + extra;
      e.loops = eff;
      sb.push_back(e);
    end
  endtask

  task automatic run(input int n, output int loads, output int ens, output int dones);
    loads = 0;
    ens   = 0;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      loads += int'(load_a);
      ens   += int'(en_a);
      dones += int'(done_a);
    end
  endtask

  task automatic wait_count(input logic [CW-1:0] v, input string tag);
    int n = 0;
    while (count_a !== v && n < 80) begin
      step();
      start = 1'b0;
      n++;
    end
    chk(tag, 32'(count_a), 32'(v));
  endtask

  // scoreboard: every done pulse must match the oldest expected completion
  always @(negedge clock) begin
    if (reset && done_a) begin
      $display("done cyc=%0d loops_done=%0d", cyc, loops_done_a);
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cyc", 32'(cyc), 32'(e.cyc));
        chk("done_loops", 32'(loops_done_a), 32'(e.loops));
      end
    end
  end

  initial begin
    int c0, loads, ens, dones;

    // reset state
    repeat (3) step();
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_en", 32'(en_a), 0);
    chk("rst_load", 32'(load_a), 0);
    chk("rst_clr", 32'(clr_a), 0);
    chk("rst_err", 32'(error_a), 0);
    chk("rst_loops", 32'(loops_done_a), 0);
    reset = 1'b1;
    step();

    // single pass 3 -> 7, cfg changed right after capture
    c0 = cyc;
    start_seq(3, 7, 1, 1'b1, 0);
    step();
    start        = 1'b0;
    cfg_load_val = 6'd50;
    cfg_target   = 6'd51;
    cfg_loops    = 8'd9;
    chk("sp_load", 32'(load_a), 1);
    chk("sp_load_val", 32'(load_val_a), 3);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk("sp_en", 32'(en_a), 1);
      chk("sp_count", 32'(count_a), 32'(k + 1));
    end
    step();
    chk("sp_count7", 32'(count_a), 7);
    chk("sp_en_off", 32'(en_a), 0);
    step();
    chk("sp_cycle7", 32'(cyc - c0), 7);
    chk("sp_busy", 32'(busy_a), 0);
    chk("sp_loops", 32'(loops_done_a), 1);
    step();

    // three passes with wrap 60 -> 2
    start_seq(60, 2, 3, 1'b1, 0);
    run(30, loads, ens, dones);
    chk("ml_loads", 32'(loads), 3);
    chk("ml_ens", 32'(ens), 18);
    chk("ml_dones", 32'(dones), 1);
    chk("ml_loops", 32'(loops_done_a), 3);

    // zero loops means one pass
    start_seq(10, 12, 0, 1'b1, 0);
    run(10, loads, ens, dones);
    chk("l0_loads", 32'(loads), 1);
    chk("l0_ens", 32'(ens), 2);
    chk("l0_loops", 32'(loops_done_a), 1);

    // start and abort together in idle: start wins
    abort = 1'b1;
    start_seq(1, 3, 2, 1'b1, 0);
    run(15, loads, ens, dones);
    chk("sa_loads", 32'(loads), 2);
    chk("sa_dones", 32'(dones), 1);
    chk("sa_loops", 32'(loops_done_a), 2);

    // hold for five cycles mid-run
    start_seq(0, 10, 1, 1'b1, 5);
    for (int i = 1; i <= 20; i++) begin
      step();
      start = 1'b0;
      if (i >= 5 && i <= 9) chk("hd_en", 32'(en_a), 0);
      if (i == 4) hold = 1'b1;
      if (i == 9) hold = 1'b0;
    end
    chk("hd_err_wd2", 32'(error_b), 0);
    chk("hd_err", 32'(error_a), 0);

    // stalled counter trips the watchdog
    stuck = 1'b1;
    start_seq(5, 20, 1, 1'b0, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      start = 1'b0;
      if (i == 3) chk("st_wd2_pre", 32'(error_b), 0);
      if (i == 4) chk("st_wd2_err", 32'(error_b), 1);
      if (i == 16) chk("st_err_pre", 32'(error_a), 0);
    end
    step();
    chk("st_err", 32'(error_a), 1);
    chk("st_en", 32'(en_a), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("st_ign_busy", 32'(busy_a), 0);
    chk("st_ign_load", 32'(load_a), 0);
    step();
    chk("st_err_hold", 32'(error_a), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("st_clr", 32'(clr_a), 1);
    step();
    chk("st_clr_off", 32'(clr_a), 0);
    chk("st_err_clr", 32'(error_a), 0);
    chk("st_err_clr_wd2", 32'(error_b), 0);
    chk("st_busy", 32'(busy_a), 0);
    stuck = 1'b0;
    step();

    // abort mid-run at count 20
    start_seq(5, 40, 1, 1'b0, 0);
    wait_count(6'd20, "ab_wait");
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_clr", 32'(clr_a), 1);
    chk("ab_en", 32'(en_a), 0);
    step();
    chk("ab_clr_off", 32'(clr_a), 0);
    chk("ab_busy", 32'(busy_a), 0);
    chk("ab_loops", 32'(loops_done_a), 0);
    run(5, loads, ens, dones);
    chk("ab_dones", 32'(dones), 0);

    // async reset mid-run, then a full rerun
    start_seq(0, 30, 1, 1'b0, 0);
    wait_count(6'd12, "rs_wait");
    reset = 1'b0;
    #1;
    chk("rs_en", 32'(en_a), 0);
    chk("rs_busy", 32'(busy_a), 0);
    chk("rs_load", 32'(load_a), 0);
    chk("rs_loops", 32'(loops_done_a), 0);
    step();
    reset = 1'b1;
    step();
    start_seq(0, 30, 1, 1'b1, 0);
    run(40, loads, ens, dones);
    chk("rr_loads", 32'(loads), 1);
    chk("rr_ens", 32'(ens), 30);
    chk("rr_dones", 32'(dones), 1);
    chk("rr_loops", 32'(loops_done_a), 1);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller that sequences the 6-bit binary counter datapath. It loads a start value, enables counting until a programmed target is reached, and repeats that pass a programmed number of times. It also supports hold, abort and a stall watchdog. It sits between the software/test-control layer (start/abort/cfg) and the counter's enable/clear/load inputs, observing the counter's count output as feedback.

Parameters:
CW, 6, counter width; matches the counter's count bus
LW, 8, loop-counter width
WDOG, 15, max consecutive RUN cycles with cnt_en=1 and count unchanged before error

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a sequence; sampled only in IDLE
abort  input  1  terminate any activity; highest priority
hold  input  1  freeze counting while in RUN
cfg_load_val  input  CW  start value for each pass
cfg_target  input  CW  terminal value for each pass
cfg_loops  input  LW  number of passes; 0 treated as 1
count  input  CW  feedback from counter datapath (registered there, 1-cycle latency from cnt_en/cnt_load)
cnt_clr  output  1  synchronous clear to counter
cnt_load  output  1  load strobe to counter
cnt_load_val  output  CW  value presented with cnt_load
cnt_en  output  1  count enable to counter
busy  output  1  high in LOAD, RUN, CLEAR
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky watchdog error flag
loops_done  output  LW  completed passes in current/last sequence

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; shadow cfg regs, watchdog and loops_done cleared.
- States: IDLE, LOAD, RUN, DONE, CLEAR, ERROR.
- IDLE: start=1 -> capture cfg_* into shadow regs, loops_done<=0, go LOAD. cfg changes after capture have no effect until the next start.
- LOAD: cnt_load=1 for exactly one cycle, cnt_load_val=shadow load value; watchdog cleared; -> RUN.
- RUN: cnt_en = ~hold & (count != target) (combinational).
  - count==target -> loops_done+1. If new value == effective loops -> DONE, else -> LOAD.
  - load_val==target: the pass completes on the first RUN cycle with zero counts.
  - Counter wrap 63->0 is legal; target is reached after the wrap (e.g. load 60, target 2 = 6 counts).
- Watchdog: counts RUN cycles with cnt_en=1 and count equal to its previous-cycle value. It resets on any count change and is frozen while hold=1. Reaching WDOG -> ERROR.
- DONE: done=1 for one cycle, busy=0 -> IDLE. loops_done holds its value until the next start.
- ERROR: error=1, cnt_en=0; start ignored. Stays until abort.
- abort=1 in any state except IDLE -> CLEAR, overriding every other transition in that cycle. In IDLE, abort is ignored.
- CLEAR: cnt_clr=1 for one cycle, error<=0, loops_done<=0 -> IDLE.
- start while busy: ignored, no queuing. start and abort together in IDLE: start wins.
- Async reset mid-RUN: outputs drop to 0 immediately; no done pulse.

Test Plan:
- Single pass, load=3, target=7, loops=1, start at cycle 0:
  - cnt_load pulse at cycle 1.
  - cnt_en high cycles 2-5.
  - count reaches 7 at cycle 6.
  - done pulse at cycle 7; loops_done=1; busy low from cycle 7.
- Multi-loop and wrap, load=60, target=2, loops=3:
  - Three LOAD pulses, each followed by 6 enabled cycles.
  - Exactly one done pulse; loops_done=3.
  - loops=0 behaves as loops=1.
- Hold, load=0, target=10, hold=1 for 5 cycles mid-RUN:
  - cnt_en low during hold; no error even with WDOG=2.
  - done pulse arrives 5 cycles later than the no-hold run.
- Stall, counter model stuck (count ignores cnt_en), WDOG=15:
  - error rises 15 RUN cycles after LOAD; start is then ignored.
  - abort gives one cnt_clr pulse, then error=0 and state IDLE.
- Abort mid-RUN, load=5, target=40, abort at count=20:
  - Next cycle: cnt_en=0 and cnt_clr=1 for one cycle; no done pulse; busy low after CLEAR.
- Async reset at count=12 of a 0->30 pass: all outputs 0 immediately; a new start after reset release runs the full sequence normally.
